ml_tile_loader: RTL and testbench

ML_TILE_LOADER -- requirements
Module: ml_tile_loader

---
 rtl/ml_tile_loader.sv | 165 ++++++++++++++++
 tb/tb_ml_tile_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_tile_loader.sv
// Tile loader: streams word bursts between a single-outstanding memory port and the
// accelerator read/write streams, buffering read data in a first-word-fall-through FIFO.
module ml_tile_loader #(
   parameter int unsigned ADDR_STEP  = 32,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [15:0] cmd_len,
   output logic [31:0] ml_addr,
   output logic [31:0] ml_data_in,
   output logic        ml_we,
   output logic        ml_re,
   input  logic [31:0] ml_data_out,
   input  logic        ml_ready,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   input  logic        rd_ready,
   input  logic        wr_valid,
   input  logic [31:0] wr_data,
   output logic        wr_ready,
   output logic        busy,
   output logic        done
);
   localparam int unsigned        PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned        CNT_W   = PTR_W + 1;
   localparam logic [31:0]        STEP    = 32'(ADDR_STEP);
   localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      WR_FETCH,
      WR_REQ,
      FINISH
   } state_t;

   state_t             state_q;
   logic [31:0]        addr_q;
   logic [15:0]        len_q;
   logic               write_q;
   logic               re_q;
   logic [31:0]        wdata_q;

   logic [31:0]        fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   occ_q;

   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               finish_ok;

   assign fifo_empty = (occ_q == '0);
   assign push       = (state_q == RD_REQ) && re_q && ml_ready;
   assign pop        = rd_ready && !fifo_empty;
   // Reads only complete once the accelerator has drained every buffered word.
   assign finish_ok  = (state_q == FINISH) && (write_q || fifo_empty);

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign done       = finish_ok;
   assign ml_addr    = addr_q;
   assign ml_data_in = wdata_q;
   assign ml_re      = re_q;
   assign ml_we      = (state_q == WR_REQ);
   assign wr_ready   = (state_q == WR_FETCH);
   assign rd_valid   = !fifo_empty;
   assign rd_data    = fifo_empty ? 32'h0 : fifo_q[rd_ptr_q];

   // Read-data FIFO storage; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= ml_data_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + CNT_W'(1);
            2'b01:   occ_q <= occ_q - CNT_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Command sequencer; a request is only ever retired while it is actually active.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         write_q <= 1'b0;
         re_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q  <= cmd_addr;
                  len_q   <= cmd_len;
                  write_q <= cmd_write;
                  if (cmd_len == 16'd0) begin
                     state_q <= FINISH;
                  end else if (cmd_write) begin
                     state_q <= WR_FETCH;
                  end else begin
                     state_q <= RD_REQ;
                  end
               end
            end
            RD_REQ: begin
               if (re_q) begin
                  if (ml_ready) begin
                     re_q   <= 1'b0;
                     addr_q <= addr_q + STEP;
                     len_q  <= len_q - 16'd1;
                     if (len_q == 16'd1) begin
                        state_q <= FINISH;
                     end
                  end
               end else if (occ_q < DEPTH_C) begin
                  re_q <= 1'b1;
               end
            end
            WR_FETCH: begin
               if (wr_valid) begin
                  wdata_q <= wr_data;
                  state_q <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (ml_ready) begin
                  addr_q  <= addr_q + STEP;
                  len_q   <= len_q - 16'd1;
                  state_q <= (len_q == 16'd1) ? FINISH : WR_FETCH;
               end
            end
            FINISH: begin
               if (finish_ok) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ml_tile_loader.sv
// Self-checking bench for ml_tile_loader: random memory latency and stream backpressure,
// transactions compared against an address-sequence model of each command.
module tb_ml_tile_loader;
   localparam int unsigned STEP  = 32;
   localparam int unsigned DEPTH = 8;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_len;
   logic [31:0] ml_addr, ml_data_in, ml_data_out;
   logic        ml_we, ml_re, ml_ready;
   logic        rd_valid, rd_ready, wr_valid, wr_ready, busy, done;
   logic [31:0] rd_data, wr_data;

   ml_tile_loader #(.ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .ml_addr(ml_addr), .ml_data_in(ml_data_in), .ml_we(ml_we), .ml_re(ml_re),
      .ml_data_out(ml_data_out), .ml_ready(ml_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .done(done)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   req_t        req_log[$];
   logic [31:0] rd_log[$];
   logic [31:0] wr_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   int          rd_req_cnt = 0;
   int          occ = 0;
   int          rd_mode = 1;
   int          lat_max = 0;
   int          lat = 0;
   bit          stray = 1'b0;
   bit          wr_xfer = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check_reset(input string tag);
      check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
      check_eq({tag, "_ml_re"}, 32'(ml_re), 0);
      check_eq({tag, "_ml_we"}, 32'(ml_we), 0);
      check_eq({tag, "_ml_addr"}, ml_addr, 0);
      check_eq({tag, "_ml_data_in"}, ml_data_in, 0);
      check_eq({tag, "_rd_valid"}, 32'(rd_valid), 0);
      check_eq({tag, "_rd_data"}, rd_data, 0);
      check_eq({tag, "_wr_ready"}, 32'(wr_ready), 0);
      check_eq({tag, "_busy"}, 32'(busy), 0);
      check_eq({tag, "_done"}, 32'(done), 0);
   endtask

   // Monitor: samples at negedge what the coming posedge will act on.
   initial begin
      bit          act_prev, rdy_prev, we_prev, re_prev;
      logic [31:0] addr_prev, data_prev;
      req_t        r;
      act_prev = 1'b0; rdy_prev = 1'b0; we_prev = 1'b0; re_prev = 1'b0;
      addr_prev = '0; data_prev = '0;
      forever begin
         @(negedge clk);
         wr_xfer = 1'b0;
         if (rst) begin
            occ = 0;
            act_prev = 1'b0; rdy_prev = 1'b0; we_prev = 1'b0; re_prev = 1'b0;
         end else begin
            check_eq("rd_valid_vs_occ", 32'(rd_valid), 32'(occ != 0));
            check_eq("re_we_excl", 32'(ml_re & ml_we), 0);
            if (act_prev && rdy_prev)
               check_eq("req_gap", 32'(ml_re | ml_we), 0);
            if (act_prev && !rdy_prev) begin
               check_eq("req_hold_act", 32'(ml_re | ml_we), 1);
               check_eq("req_hold_addr", ml_addr, addr_prev);
               if (we_prev) check_eq("req_hold_data", ml_data_in, data_prev);
            end
            if (ml_re && !re_prev) begin
               rd_req_cnt++;
               check_eq("re_fifo_room", 32'(occ < int'(DEPTH)), 1);
            end
            if (ml_ready && (ml_re || ml_we)) begin
               r.we   = ml_we;
               r.addr = ml_addr;
               r.data = ml_we ? ml_data_in : ml_data_out;
               req_log.push_back(r);
               if (ml_re) occ++;
            end
            wr_xfer = wr_valid && wr_ready;
            if (rd_valid && rd_ready) begin
               rd_log.push_back(rd_data);
               occ--;
            end
            if (done) done_cnt++;
            act_prev  = ml_re || ml_we;
            rdy_prev  = ml_ready;
            we_prev   = ml_we;
            re_prev   = ml_re;
            addr_prev = ml_addr;
            data_prev = ml_data_in;
         end
      end
   end

   // Memory responder and stream drivers, updated just after each posedge.
   initial begin
      ml_ready = 1'b0; ml_data_out = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (stray) begin
            ml_ready = 1'b1;
            ml_data_out = $urandom;
         end else if (ml_ready) begin
            ml_ready = 1'b0;
            ml_data_out = $urandom;
         end else if ((ml_re || ml_we) && !rst) begin
            if (lat == 0) begin
               ml_ready = 1'b1;
               ml_data_out = mem_word(ml_addr);
               lat = $urandom_range(lat_max, 0);
            end else begin
               lat--;
            end
         end else begin
            ml_data_out = $urandom;
         end
         if (wr_xfer) begin
            void'(wr_q.pop_front());
            wr_valid = 1'b0;
         end
         if (!wr_valid) begin
            if (wr_q.size() > 0 && $urandom_range(2, 0) != 0) begin
               wr_valid = 1'b1;
               wr_data  = wr_q[0];
            end else begin
               wr_data = $urandom;
            end
         end
         case (rd_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            default: rd_ready = 1'($urandom_range(1, 0));
         endcase
      end
   end

   task automatic start_cmd(input bit w, input logic [31:0] a, input int len, input logic [31:0] wbase);
      int k;
      req_log.delete(); rd_log.delete();
      done_cnt = 0; rd_req_cnt = 0;
      if (w) for (int i = 0; i < len; i++) wr_q.push_back(wbase + 32'(i));
      k = 0;
      while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
      check_eq("cmd_ready_wait", 32'(cmd_ready), 1);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = 16'(len);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = $urandom; cmd_len = 16'($urandom);
   endtask

   task automatic finish_cmd(input bit w, input logic [31:0] a, input int len, input logic [31:0] wbase);
      int          k;
      logic [31:0] ea, ed;
      k = 0;
      while (done_cnt == 0 && k < 4000) begin @(posedge clk); #1; k++; end
      repeat (6) @(posedge clk);
      #1;
      check_eq("done_count", 32'(done_cnt), 1);
      check_eq("req_count", 32'(req_log.size()), 32'(len));
      for (int i = 0; i < len; i++) begin
         ea = a + 32'(i) * STEP;
         ed = w ? wbase + 32'(i) : mem_word(ea);
         if (i < req_log.size()) begin
            check_eq("req_we", 32'(req_log[i].we), 32'(w));
            check_eq("req_addr", req_log[i].addr, ea);
            check_eq("req_data", req_log[i].data, ed);
         end
         if (!w && i < rd_log.size()) check_eq("rd_data", rd_log[i], ed);
      end
      check_eq("rd_count", 32'(rd_log.size()), w ? 32'd0 : 32'(len));
      if (w) check_eq("re_during_write", 32'(rd_req_cnt), 0);
      check_eq("wr_left", 32'(wr_q.size()), 0);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_cmd_ready", 32'(cmd_ready), 1);
   endtask

   initial begin
      int k;
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("rst_init");
      @(posedge clk); #1;
      rst = 1'b0;

      // Basic read burst with one-cycle memory latency.
      rd_mode = 1; lat_max = 0;
      start_cmd(1'b0, 32'h100, 4, 0);
      finish_cmd(1'b0, 32'h100, 4, 0);

      // Read stalls at FIFO capacity while the stream is blocked.
      rd_mode = 0;
      start_cmd(1'b0, 32'h1000, 12, 0);
      repeat (80) @(posedge clk);
      #1;
      check_eq("stall_req_issued", 32'(rd_req_cnt), 8);
      check_eq("stall_ml_re", 32'(ml_re), 0);
      check_eq("stall_rd_count", 32'(rd_log.size()), 0);
      check_eq("stall_no_done", 32'(done_cnt), 0);
      rd_mode = 1;
      finish_cmd(1'b0, 32'h1000, 12, 0);

      // Write burst with gaps on wr_valid and variable latency.
      rd_mode = 2; lat_max = 2;
      start_cmd(1'b1, 32'h0, 3, 32'hA);
      finish_cmd(1'b1, 32'h0, 3, 32'hA);

      // Zero-length commands.
      start_cmd(1'b0, 32'h200, 0, 0);
      @(negedge clk);
      check_eq("len0_cmd_ready", 32'(cmd_ready), 0);
      check_eq("len0_done", 32'(done), 1);
      check_eq("len0_busy", 32'(busy), 1);
      @(negedge clk);
      check_eq("len0_back_idle", 32'(cmd_ready), 1);
      check_eq("len0_done_low", 32'(done), 0);
      @(posedge clk); #1;
      finish_cmd(1'b0, 32'h200, 0, 0);
      start_cmd(1'b1, 32'h240, 0, 0);
      finish_cmd(1'b1, 32'h240, 0, 0);

      // Reset while the second read word is outstanding, plus a stray ml_ready after it.
      rd_mode = 0; lat_max = 0;
      start_cmd(1'b0, 32'h300, 4, 0);
      k = 0;
      while (!(req_log.size() == 1 && ml_re) && k < 100) begin @(posedge clk); #1; k++; end
      check_eq("mid_second_req", 32'(ml_re), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; stray = 1'b1;
      @(negedge clk);
      check_reset("rst_mid");
      @(posedge clk); #1;
      stray = 1'b0;
      @(negedge clk);
      check_eq("stray_cmd_ready", 32'(cmd_ready), 1);
      check_eq("stray_busy", 32'(busy), 0);
      check_eq("stray_ml_re", 32'(ml_re), 0);
      check_eq("stray_rd_valid", 32'(rd_valid), 0);
      repeat (4) @(posedge clk);
      #1;
      check_eq("rst_no_done", 32'(done_cnt), 0);
      rd_mode = 2;
      start_cmd(1'b0, 32'h400, 5, 0);
      finish_cmd(1'b0, 32'h400, 5, 0);

      // Address wrap past the top of the space.
      rd_mode = 1;
      start_cmd(1'b0, 32'hFFFF_FFE0, 2, 0);
      finish_cmd(1'b0, 32'hFFFF_FFE0, 2, 0);

      // Randomized commands.
      for (int t = 0; t < 25; t++) begin
         bit          w;
         logic [31:0] a, wb;
         int          len;
         w       = 1'($urandom_range(1, 0));
         a       = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'hE0)) : $urandom;
         len     = $urandom_range(20, 0);
         wb      = $urandom;
         lat_max = $urandom_range(3, 0);
         rd_mode = $urandom_range(2, 1);
         start_cmd(w, a, len, wb);
         finish_cmd(w, a, len, wb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
